dc_filter_ctrl: RTL and testbench

DC_FILTER_CTRL -- requirements
Module: dc_filter_ctrl

---
 rtl/dc_filter_ctrl.sv | 132 +++++++++++++
 tb/tb_dc_filter_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dc_filter_ctrl.sv
// DC filter sequencing controller.
// Generates the 3 MHz sample strobe from the 24 MHz clock and walks the DC
// filter through reset, fast settling, normal tracking and estimate hold.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | filter held in reset, waiting for start
//   CLEAR  | filter held in reset for two 3 MHz strobes
//   SETTLE | fast coefficient for the latched number of strobes
//   RUN    | normal coefficient, output samples valid
//   HOLD   | DC estimate frozen, output samples still valid
module dc_filter_ctrl (
  input  logic        CLK_24M,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        freeze,
  input  logic [15:0] settle_len,
  output logic        enable_3M,
  output logic        filter_rst_n,
  output logic [1:0]  k_sel,
  output logic        data_valid,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    SETTLE = 3'd2,
    RUN    = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  prescaler;
  logic [1:0]  clr_cnt;
  logic [15:0] settle_cnt;
  logic [15:0] settle_len_q;
  logic        restart;

  // A start that is not overridden by stop (re)enters CLEAR from any state.
  assign restart = start && !stop;
  assign state_o = state;

  // Free-running divide-by-8; the strobe is registered off the 7->0 wrap.
  always_ff @(posedge CLK_24M or posedge reset) begin
    if (reset) begin
      prescaler <= 3'd0;
      enable_3M <= 1'b0;
    end else begin
      prescaler <= prescaler + 3'd1;
      enable_3M <= (prescaler == 3'd7);
    end
  end

  // Next-state decode: stop beats start, start beats freeze-driven moves.
  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = IDLE;
    end else if (start) begin
      state_nxt = CLEAR;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        CLEAR: begin
          if (enable_3M && clr_cnt == 2'd1)
            state_nxt = (settle_len_q == 16'd0) ? RUN : SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == settle_len_q)
            state_nxt = RUN;
        end
        RUN: begin
          if (freeze)
            state_nxt = HOLD;
        end
        HOLD: begin
          if (!freeze)
            state_nxt = RUN;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Strobe counters for CLEAR and SETTLE, plus the settle length snapshot.
  always_ff @(posedge CLK_24M or posedge reset) begin
    if (reset) begin
      clr_cnt      <= 2'd0;
      settle_cnt   <= 16'd0;
      settle_len_q <= 16'd0;
    end else begin
      if (restart)
        settle_len_q <= settle_len;

      if (restart || state != CLEAR)
        clr_cnt <= 2'd0;
      else if (enable_3M)
        clr_cnt <= clr_cnt + 2'd1;

      // Counter stays at zero outside SETTLE, so it is clear on every entry.
      if (restart || state != SETTLE)
        settle_cnt <= 16'd0;
      else if (enable_3M && settle_cnt != settle_len_q)
        settle_cnt <= settle_cnt + 16'd1;
    end
  end

  // State register and outputs decoded from the next state so they line up.
  always_ff @(posedge CLK_24M or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      filter_rst_n <= 1'b0;
      k_sel        <= 2'd0;
      data_valid   <= 1'b0;
    end else begin
      state        <= state_nxt;
      filter_rst_n <= (state_nxt == SETTLE) || (state_nxt == RUN) || (state_nxt == HOLD);
      case (state_nxt)
        RUN:     k_sel <= 2'd1;
        HOLD:    k_sel <= 2'd2;
        default: k_sel <= 2'd0;
      endcase
      // Strobe delayed one clock to match the filter's output register,
      // dropped if the sequence leaves RUN/HOLD on this edge.
      data_valid   <= enable_3M && ((state_nxt == RUN) || (state_nxt == HOLD));
    end
  end

endmodule

// File: tb/tb_dc_filter_ctrl.sv
// Scoreboard bench for dc_filter_ctrl: a driver applies inputs at the falling
// edge and queues the reference response; a monitor checks after each rise.
module tb_dc_filter_ctrl;

  localparam int S_IDLE   = 0;
  localparam int S_CLEAR  = 1;
  localparam int S_SETTLE = 2;
  localparam int S_RUN    = 3;
  localparam int S_HOLD   = 4;

  typedef struct packed {
    logic [2:0] st;
    logic       frn;
    logic [1:0] k;
    logic       en;
    logic       dv;
  } obs_t;

  logic        CLK_24M = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        freeze = 1'b0;
  logic [15:0] settle_len = 16'd0;
  logic        enable_3M;
  logic        filter_rst_n;
  logic [1:0]  k_sel;
  logic        data_valid;
  logic [2:0]  state_o;

  int n_vec = 0;
  int n_err = 0;

  obs_t exp_q[$];

  // reference model: edges since reset release, phase, strobe bookkeeping
  int m_edge;
  int m_st;
  int m_clr_seen;
  int m_settle_seen;
  int m_len;
  bit m_en;
  bit m_dv;

  dc_filter_ctrl dut (
    .CLK_24M      (CLK_24M),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .freeze       (freeze),
    .settle_len   (settle_len),
    .enable_3M    (enable_3M),
    .filter_rst_n (filter_rst_n),
    .k_sel        (k_sel),
    .data_valid   (data_valid),
    .state_o      (state_o)
  );

  always #5 CLK_24M = ~CLK_24M;

  task automatic model_reset();
    m_edge = 0;
    m_st = S_IDLE;
    m_clr_seen = 0;
    m_settle_seen = 0;
    m_len = 0;
    m_en = 1'b0;
    m_dv = 1'b0;
  endtask

  // Predicts the outputs after the next rising edge given the inputs now.
  function automatic obs_t model_edge(input bit s, input bit p, input bit f, input int len);
    obs_t o;
    bit   strobe_before;
    strobe_before = m_en;
    m_edge = m_edge + 1;
    if (p) begin
      m_st = S_IDLE;
    end else if (s) begin
      m_st = S_CLEAR;
      m_len = len;
      m_clr_seen = 0;
      m_settle_seen = 0;
    end else if (m_st == S_CLEAR) begin
      if (strobe_before) begin
        m_clr_seen = m_clr_seen + 1;
        if (m_clr_seen == 2) begin
          m_st = (m_len == 0) ? S_RUN : S_SETTLE;
          m_settle_seen = 0;
        end
      end
    end else if (m_st == S_SETTLE) begin
      if (m_settle_seen == m_len) m_st = S_RUN;
      else if (strobe_before) m_settle_seen = m_settle_seen + 1;
    end else if (m_st == S_RUN) begin
      if (f) m_st = S_HOLD;
    end else if (m_st == S_HOLD) begin
      if (!f) m_st = S_RUN;
    end
    m_en = (m_edge % 8 == 0);
    m_dv = strobe_before && (m_st == S_RUN || m_st == S_HOLD);
    o.st  = 3'(m_st);
    o.frn = (m_st == S_SETTLE || m_st == S_RUN || m_st == S_HOLD);
    o.k   = (m_st == S_RUN) ? 2'd1 : (m_st == S_HOLD) ? 2'd2 : 2'd0;
    o.en  = m_en;
    o.dv  = m_dv;
    return o;
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit s, input bit p, input bit f, input logic [15:0] len);
    obs_t e;
    start = s;
    stop = p;
    freeze = f;
    settle_len = len;
    e = model_edge(s, p, f, int'(len));
    exp_q.push_back(e);
    @(negedge CLK_24M);
  endtask

  task automatic idle_cycles(input int n, input bit f);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, f, 16'($urandom));
  endtask

  task automatic check_reset(input string name);
    obs_t got;
    got = '{st: state_o, frn: filter_rst_n, k: k_sel, en: enable_3M, dv: data_valid};
    n_vec++;
    if (got !== obs_t'(0)) begin
      n_err++;
      $display("FAIL %s: got st=%0d frn=%0b k=%0d en=%0b dv=%0b, want all zero",
               name, got.st, got.frn, got.k, got.en, got.dv);
    end
  endtask

  // Called at a falling edge; reset is raised mid-cycle and released later.
  task automatic pulse_reset(input string name);
    start = 1'b0;
    stop = 1'b0;
    freeze = 1'b0;
    #1 reset = 1'b1;
    #1 check_reset(name);
    repeat (3) @(posedge CLK_24M);
    #1 check_reset({name, "_held"});
    @(negedge CLK_24M);
    reset = 1'b0;
    model_reset();
  endtask

  // Monitor: compares every DUT output set against the queued prediction.
  always @(posedge CLK_24M) begin
    obs_t got;
    obs_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = '{st: state_o, frn: filter_rst_n, k: k_sel, en: enable_3M, dv: data_valid};
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL cycle t=%0t: got st=%0d frn=%0b k=%0d en=%0b dv=%0b, want st=%0d frn=%0b k=%0d en=%0b dv=%0b",
                 $time, got.st, got.frn, got.k, got.en, got.dv, e.st, e.frn, e.k, e.en, e.dv);
      end
    end
  end

  initial begin
    bit fr;
    model_reset();
    #1 reset = 1'b1;
    #1 check_reset("reset_initial");
    repeat (2) @(negedge CLK_24M);
    reset = 1'b0;

    // strobe cadence with no start
    idle_cycles(40, 1'b0);

    // settle_len=4 full sequence, then freeze into HOLD and back
    step(1'b1, 1'b0, 1'b0, 16'd4);
    idle_cycles(80, 1'b0);
    idle_cycles(160, 1'b1);
    idle_cycles(40, 1'b0);

    // settle_len=0 skips SETTLE
    step(1'b1, 1'b0, 1'b0, 16'd0);
    idle_cycles(60, 1'b0);

    // restart inside SETTLE with a shorter length, then start+stop together
    step(1'b1, 1'b0, 1'b0, 16'd7);
    idle_cycles(30, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'd2);
    idle_cycles(50, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'd3);
    idle_cycles(10, 1'b0);

    // stop while running
    step(1'b1, 1'b0, 1'b0, 16'd1);
    idle_cycles(40, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'd1);
    idle_cycles(10, 1'b0);

    // reset during SETTLE
    step(1'b1, 1'b0, 1'b0, 16'd5);
    idle_cycles(30, 1'b0);
    pulse_reset("reset_in_settle");
    idle_cycles(20, 1'b0);

    // random traffic
    fr = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) fr = ~fr;
      if ($urandom_range(0, 1999) == 0) begin
        pulse_reset("reset_random");
      end else begin
        step(($urandom_range(0, 99) == 0), ($urandom_range(0, 249) == 0), fr,
             16'($urandom_range(0, 5)));
      end
    end

    start = 1'b0;
    stop = 1'b0;
    repeat (2) @(posedge CLK_24M);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d predictions left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
